// File: rtl/decode_stage.sv
// LC-3 decode pipeline stage: registers the fetched instruction and next-PC and
// produces the execute, memory and writeback control words one cycle later.
module decode_stage #(
  parameter int IW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_decode,
  input  logic          flush,
  input  logic [IW-1:0] dout,
  input  logic [IW-1:0] npc_in,
  output logic [IW-1:0] IR,
  output logic [IW-1:0] npc_out,
  output logic [5:0]    E_Control,
  output logic          Mem_Control,
  output logic [1:0]    W_Control,
  output logic          decode_valid,
  output logic          illegal_op
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
    OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2;
  } e_ctrl_t;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_PC  = 2'b01;
  localparam logic [1:0] W_MEM = 2'b10;

  e_ctrl_t       e_d, e_q;
  logic [1:0]    w_d, w_q;
  logic          mem_d, mem_q;
  logic          ill_d, ill_q;
  logic          valid_q;
  logic [IW-1:0] ir_q, npc_q;

  // Pure decode of the incoming instruction; only consumed when capturing.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves a signal unassigned (which would infer a latch).
    e_d   = '0;
    w_d   = W_ALU;
    mem_d = 1'b0;
    ill_d = 1'b0;
    case (dout[15:12])
      OP_ADD: e_d = '{alu: 2'b00, pcsel1: 2'b00, pcsel2: 1'b0, op2: ~dout[5]};
      OP_AND: e_d = '{alu: 2'b01, pcsel1: 2'b00, pcsel2: 1'b0, op2: ~dout[5]};
      OP_NOT: e_d = '{alu: 2'b10, pcsel1: 2'b00, pcsel2: 1'b0, op2: 1'b1};
      OP_BR,
      OP_ST:  e_d = '{alu: 2'b00, pcsel1: 2'b01, pcsel2: 1'b1, op2: 1'b0};
      OP_JMP: e_d = '{alu: 2'b00, pcsel1: 2'b11, pcsel2: 1'b0, op2: 1'b0};
      OP_LD: begin
        e_d = '{alu: 2'b00, pcsel1: 2'b01, pcsel2: 1'b1, op2: 1'b0};
        w_d = W_MEM;
      end
      OP_LDR: begin
        e_d = '{alu: 2'b00, pcsel1: 2'b10, pcsel2: 1'b0, op2: 1'b0};
        w_d = W_MEM;
      end
      OP_STR: e_d = '{alu: 2'b00, pcsel1: 2'b10, pcsel2: 1'b0, op2: 1'b0};
      OP_LDI: begin
        e_d   = '{alu: 2'b00, pcsel1: 2'b01, pcsel2: 1'b1, op2: 1'b0};
        w_d   = W_MEM;
        mem_d = 1'b1;
      end
      OP_STI: begin
        e_d   = '{alu: 2'b00, pcsel1: 2'b01, pcsel2: 1'b1, op2: 1'b0};
        mem_d = 1'b1;
      end
      OP_LEA: begin
        e_d = '{alu: 2'b00, pcsel1: 2'b01, pcsel2: 1'b1, op2: 1'b0};
        w_d = W_PC;
      end
      default: ill_d = 1'b1;  // 0100, 1000, 1101, 1111
    endcase
  end

  // Reset and flush both leave a NOP in the stage and drop any capture.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset || flush) begin
      ir_q    <= '0;
      npc_q   <= '0;
      e_q     <= '0;
      w_q     <= W_ALU;
      mem_q   <= 1'b0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (enable_decode) begin
      ir_q    <= dout;
      npc_q   <= npc_in;
      e_q     <= e_d;
      w_q     <= w_d;
      mem_q   <= mem_d;
      ill_q   <= ill_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_q;
  assign Mem_Control  = mem_q;
  assign W_Control    = w_q;
  assign decode_valid = valid_q;
  assign illegal_op   = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan sequences pinned with
// literal expectations, then randomized traffic against an instruction-class model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, enable_decode, flush;
  logic [15:0] dout, npc_in;
  logic [15:0] IR, npc_out;
  logic [5:0]  E_Control;
  logic        Mem_Control;
  logic [1:0]  W_Control;
  logic        decode_valid, illegal_op;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Expected outputs, maintained by the model
  logic [15:0] exp_ir, exp_npc;
  logic [5:0]  exp_e;
  logic [1:0]  exp_w;
  logic        exp_mem, exp_valid, exp_ill;

  decode_stage dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .flush        (flush),
    .dout         (dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .Mem_Control  (Mem_Control),
    .W_Control    (W_Control),
    .decode_valid (decode_valid),
    .illegal_op   (illegal_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-class view of the ISA: which operand path, which writeback
  // source, whether memory is accessed indirectly.
  task automatic model_decode(input logic [15:0] instr);
    int op;
    bit pc_rel9, base_off6;
    op        = int'(instr[15:12]);
    pc_rel9   = (op == 0) || (op == 2) || (op == 3) || (op == 10) || (op == 11) || (op == 14);
    base_off6 = (op == 6) || (op == 7);
    exp_ill   = (op == 4) || (op == 8) || (op == 13) || (op == 15);
    exp_e     = '0;
    exp_w     = 2'd0;
    exp_mem   = (op == 10) || (op == 11);
    if (op == 2 || op == 6 || op == 10) exp_w = 2'd2;
    if (op == 14) exp_w = 2'd1;
    if (pc_rel9)   exp_e[3:1] = 3'b011;
    if (base_off6) exp_e[3:1] = 3'b100;
    if (op == 12)  exp_e[3:1] = 3'b110;
    if (op == 1)   exp_e[0] = !instr[5];
    if (op == 5) begin exp_e[5:4] = 2'd1; exp_e[0] = !instr[5]; end
    if (op == 9) begin exp_e[5:4] = 2'd2; exp_e[0] = 1'b1; end
  endtask

  task automatic model_clear();
    exp_ir = '0; exp_npc = '0; exp_e = '0; exp_w = '0;
    exp_mem = 1'b0; exp_ill = 1'b0; exp_valid = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle #1 after it.
  task automatic step(input logic r, input logic f, input logic en,
                      input logic [15:0] d, input logic [15:0] n);
    @(negedge clock);
    reset = r; flush = f; enable_decode = en; dout = d; npc_in = n;
    @(posedge clock);
    if (r || f) model_clear();
    else if (en) begin
      exp_ir = d; exp_npc = n; exp_valid = 1'b1;
      model_decode(d);
    end else exp_valid = 1'b0;
    #1;
  endtask

  // Compare process: every cycle once the stage has been reset.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("IR", IR, exp_ir);
      check("npc_out", npc_out, exp_npc);
      check("E_Control", {10'd0, E_Control}, {10'd0, exp_e});
      check("W_Control", {14'd0, W_Control}, {14'd0, exp_w});
      check("Mem_Control", {15'd0, Mem_Control}, {15'd0, exp_mem});
      check("decode_valid", {15'd0, decode_valid}, {15'd0, exp_valid});
      check("illegal_op", {15'd0, illegal_op}, {15'd0, exp_ill});
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; enable_decode = 1'b0; dout = '0; npc_in = '0;
    model_clear();

    // Reset then idle
    step(1, 0, 0, 16'h0, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0);
    cmp_en = 1'b1;
    check("rst_IR", IR, 16'h0000);
    check("rst_valid", {15'd0, decode_valid}, 16'd0);
    step(0, 0, 0, 16'hFFFF, 16'hFFFF);
    step(0, 0, 0, 16'h1234, 16'h5678);
    check("idle_IR", IR, 16'h0000);
    check("idle_E", {10'd0, E_Control}, 16'd0);

    // ADD immediate
    step(0, 0, 1, 16'h1261, 16'h3001);
    check("add_IR", IR, 16'h1261);
    check("add_npc", npc_out, 16'h3001);
    check("add_E", {10'd0, E_Control}, 16'b000000);
    check("add_valid", {15'd0, decode_valid}, 16'd1);

    // AND register form, then hold (second hold cycle with X on dout)
    step(0, 0, 1, 16'h5042, 16'h3002);
    check("and_E", {10'd0, E_Control}, 16'b010001);
    check("and_valid", {15'd0, decode_valid}, 16'd1);
    step(0, 0, 0, 16'h9FFF, 16'hAAAA);
    check("hold1_E", {10'd0, E_Control}, 16'b010001);
    check("hold1_valid", {15'd0, decode_valid}, 16'd0);
    step(0, 0, 0, 16'hxxxx, 16'hxxxx);
    check("hold2_E", {10'd0, E_Control}, 16'b010001);
    check("hold2_IR", IR, 16'h5042);
    check("hold2_valid", {15'd0, decode_valid}, 16'd0);

    // Memory ops back to back
    step(0, 0, 1, 16'hA405, 16'h3010);
    check("ldi_E", {10'd0, E_Control}, 16'b000110);
    check("ldi_W", {14'd0, W_Control}, 16'd2);
    check("ldi_M", {15'd0, Mem_Control}, 16'd1);
    step(0, 0, 1, 16'hE1FF, 16'h3011);
    check("lea_E", {10'd0, E_Control}, 16'b000110);
    check("lea_W", {14'd0, W_Control}, 16'd1);
    check("lea_M", {15'd0, Mem_Control}, 16'd0);
    step(0, 0, 1, 16'hB602, 16'h3012);
    check("sti_W", {14'd0, W_Control}, 16'd0);
    check("sti_M", {15'd0, Mem_Control}, 16'd1);
    step(0, 0, 1, 16'h6283, 16'h3013);
    check("ldr_E", {10'd0, E_Control}, 16'b001000);
    check("ldr_W", {14'd0, W_Control}, 16'd2);
    check("ldr_valid", {15'd0, decode_valid}, 16'd1);

    // Illegal opcode, then flush overriding an enable
    step(0, 0, 1, 16'hF025, 16'h3014);
    check("trap_ill", {15'd0, illegal_op}, 16'd1);
    check("trap_E", {10'd0, E_Control}, 16'd0);
    check("trap_IR", IR, 16'hF025);
    step(0, 1, 1, 16'h1000, 16'h3015);
    check("flush_IR", IR, 16'h0000);
    check("flush_ill", {15'd0, illegal_op}, 16'd0);
    check("flush_valid", {15'd0, decode_valid}, 16'd0);

    // Reset mid-stream drops a simultaneous capture
    step(0, 0, 1, 16'hC1C0, 16'h3020);
    check("jmp_E", {10'd0, E_Control}, 16'b001100);
    step(1, 0, 1, 16'h9FFF, 16'h3021);
    check("rstmid_IR", IR, 16'h0000);
    check("rstmid_E", {10'd0, E_Control}, 16'd0);
    check("rstmid_npc", npc_out, 16'h0000);

    // NOT pins the alu/op2 encoding; illegal clears on next legal decode
    step(0, 0, 1, 16'h8000, 16'h4000);
    check("rti_ill", {15'd0, illegal_op}, 16'd1);
    step(0, 0, 1, 16'h9A3F, 16'h4001);
    check("not_E", {10'd0, E_Control}, 16'b100001);
    check("not_ill", {15'd0, illegal_op}, 16'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, f, en;
      logic [15:0] d;
      r  = ($urandom_range(63) == 0);
      f  = ($urandom_range(15) == 0);
      en = ($urandom_range(9) < 7);
      d  = 16'($urandom);
      if (!en && $urandom_range(3) == 0) d = 16'hxxxx;
      step(r, f, en, d, 16'($urandom));
    end

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RTL LC-3 decode pipeline stage. It is the producing end of the decode_out interface: it drives IR, E_Control, npc_out, Mem_Control and W_Control into the execute stage.
- Takes the fetched instruction (dout) and next-PC (npc_in) from fetch, registers them, and generates execute, memory and writeback control words.
- Verification environment: the decode_in agent drives its inputs; the decode_out agent in monitor/initiator mode samples its outputs.

Parameters:
- IW, 16, instruction and PC width. Fixed at 16 for LC-3; only the default is supported.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable_decode  input  1  capture and decode dout/npc_in this cycle.
- flush  input  1  replace stage contents with a NOP.
- dout  input  16  instruction from fetch/instruction memory.
- npc_in  input  16  PC+1 from fetch.
- IR  output  16  registered instruction.
- npc_out  output  16  registered npc_in.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- Mem_Control  output  1  1 = indirect access (LDI/STI).
- W_Control  output  2  writeback source: 00 ALU, 01 PC-relative address (LEA), 10 memory.
- decode_valid  output  1  outputs hold a freshly decoded instruction.
- illegal_op  output  1  registered IR opcode is unsupported.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (sync, highest priority): every output goes to 0. IR = 16'h0000 is a BR with nzp = 000, i.e. a NOP.
- Priority each posedge: reset > flush > enable_decode > hold.
- flush = 1: IR = 0, npc_out = 0, E_Control = 0, Mem_Control = 0, W_Control = 00, illegal_op = 0, decode_valid = 0. This applies regardless of enable_decode.
- enable_decode = 1 (no flush): IR <= dout, npc_out <= npc_in, control words per the table below, decode_valid <= 1.
  - Latency: 1 cycle from input to output.
- enable_decode = 0 (no flush): all outputs hold their values, except decode_valid <= 0.
- Back-to-back enables give one new decode per cycle with no bubble.
- Decode table, keyed on dout[15:12] (alu, pcsel1, pcsel2, op2, W, Mem):
  - ADD 0001: 00, 00, 0, op2, 00, 0. op2 = ~dout[5] (0 selects imm5, 1 selects VSR2).
  - AND 0101: 01, 00, 0, op2, 00, 0. op2 = ~dout[5].
  - NOT 1001: 10, 00, 0, 1, 00, 0.
  - BR 0000: 00, 01, 1, 0, 00, 0.
  - JMP 1100: 00, 11, 0, 0, 00, 0.
  - LD 0010: 00, 01, 1, 0, 10, 0.
  - LDR 0110: 00, 10, 0, 0, 10, 0.
  - LDI 1010: 00, 01, 1, 0, 10, 1.
  - LEA 1110: 00, 01, 1, 0, 01, 0.
  - ST 0011: 00, 01, 1, 0, 00, 0.
  - STR 0111: 00, 10, 0, 0, 00, 0.
  - STI 1011: 00, 01, 1, 0, 00, 1.
- Opcodes 0100, 1000, 1101, 1111: IR and npc_out are still captured; E_Control = 0, Mem_Control = 0, W_Control = 00, illegal_op = 1. illegal_op clears on the next enabled legal decode, on flush, or on reset.
- pcselect1 encoding: 00 offset11, 01 offset9, 10 offset6, 11 zero. pcselect2: 1 = npc, 0 = VSR1.
- No X propagation: an X on dout[15:12] while enable_decode = 0 has no effect.
- Reset or flush in the same cycle as enable_decode: that capture is dropped.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles → all outputs 0, decode_valid = 0; enable_decode = 0 afterwards keeps them at 0.
- ADD imm: dout = 16'h1261, npc_in = 16'h3001, enable = 1 → next cycle IR = 1261, npc_out = 3001, E_Control = 6'b000000, W = 00, Mem = 0, decode_valid = 1.
- AND reg, then hold: dout = 16'h5042 then enable = 0 → E_Control = 6'b010001, held for 3 cycles with decode_valid = 1, 0, 0.
- Memory ops back-to-back (LDI 16'hA405, LEA 16'hE1FF, STI 16'hB602, LDR 16'h6283) → successive cycles give:
  - LDI: E = 6'b000110, W = 10, Mem = 1.
  - LEA: E = 6'b000110, W = 01, Mem = 0.
  - STI: E = 6'b000110, W = 00, Mem = 1.
  - LDR: E = 6'b001000, W = 10, Mem = 0.
- Illegal and flush: dout = 16'hF025 (TRAP), enable = 1 → illegal_op = 1, E = 0. Next cycle flush = 1 with enable = 1 and dout = 16'h1000 → IR = 0, illegal_op = 0, decode_valid = 0.
- Reset mid-stream: JMP 16'hC1C0 decoded (E = 6'b001100), then reset asserted together with enable = 1 and dout = 16'h9FFF → all outputs 0 next cycle, NOT not captured.
